// File: rtl/byte_lane_rr_scheduler_if.sv
// ============================================================================
// Module      : byte_lane_rr_scheduler_if
// Description : Bundle of requester-side and lane-side signals for the
//               byte_lane_rr_scheduler.
//               The master modport is the environment: word sources and the
//               lane consumer. The slave modport is the scheduler itself.
// Ports       : (interface signals)
//   valid_in_0..3  requester N holds a word
//   data_in_0..3   word from requester N (8*BYTES_PER_WORD bits)
//   ready_0..3     word from requester N is accepted this cycle
//   data_out       serialised byte
//   valid_out      data_out carries a word byte
//   lane_out       requester index of the current byte
//   sow_out        first byte of a word
//   eow_out        last byte of a word
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface byte_lane_rr_scheduler_if #(
  parameter int BYTES_PER_WORD = 4
);
  logic                          valid_in_0;
  logic                          valid_in_1;
  logic                          valid_in_2;
  logic                          valid_in_3;
  logic [8*BYTES_PER_WORD-1:0]   data_in_0;
  logic [8*BYTES_PER_WORD-1:0]   data_in_1;
  logic [8*BYTES_PER_WORD-1:0]   data_in_2;
  logic [8*BYTES_PER_WORD-1:0]   data_in_3;
  logic                          ready_0;
  logic                          ready_1;
  logic                          ready_2;
  logic                          ready_3;
  logic [7:0]                    data_out;
  logic                          valid_out;
  logic [1:0]                    lane_out;
  logic                          sow_out;
  logic                          eow_out;

  modport master (
    output valid_in_0, valid_in_1, valid_in_2, valid_in_3,
    output data_in_0, data_in_1, data_in_2, data_in_3,
    input  ready_0, ready_1, ready_2, ready_3,
    input  data_out, valid_out, lane_out, sow_out, eow_out
  );

  modport slave (
    input  valid_in_0, valid_in_1, valid_in_2, valid_in_3,
    input  data_in_0, data_in_1, data_in_2, data_in_3,
    output ready_0, ready_1, ready_2, ready_3,
    output data_out, valid_out, lane_out, sow_out, eow_out
  );
endinterface

`default_nettype wire

// File: rtl/byte_lane_rr_scheduler.sv
// ============================================================================
// Module      : byte_lane_rr_scheduler
// Description : Round-robin scheduler sharing one 8-bit byte lane among four
//               word requesters. Accepts one word from the winning requester
//               and serialises it MSB byte first, one byte per clock, tagged
//               with source lane and start/end-of-word markers.
//               Optional feature macro: COMMA_EN (idle lane carries IDLE_BYTE
//               instead of 8'h00).
// Ports       :
//   clk      in   single clock, all state on posedge
//   reset_L  in   asynchronous active-low reset
//   bus      slave modport of byte_lane_rr_scheduler_if:
//              valid_in_0..3 / data_in_0..3 in, ready_0..3 out (combinational),
//              data_out / valid_out / lane_out / sow_out / eow_out out (registered)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_lane_rr_scheduler #(
  parameter int         BYTES_PER_WORD = 4,
  parameter logic [7:0] IDLE_BYTE      = 8'hBC
) (
  input  wire logic              clk,
  input  wire logic              reset_L,
  byte_lane_rr_scheduler_if.slave bus
);

  localparam int WORD_W = 8 * BYTES_PER_WORD;
  localparam int CNT_W  = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES_PER_WORD - 1);

`ifdef COMMA_EN
  localparam logic [7:0] IDLE_VAL = IDLE_BYTE;
`else
  // Idle lane carries zero; IDLE_BYTE is masked so both builds reference it.
  localparam logic [7:0] IDLE_VAL = IDLE_BYTE & 8'h00;
`endif

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    byte_cnt_q;   // index of the byte currently on data_out
  logic [1:0]          rr_ptr_q;
  logic [WORD_W-1:0]   shift_q;      // bytes still to be emitted, MSB aligned
  logic [7:0]          data_out_q;
  logic                valid_out_q;
  logic [1:0]          lane_out_q;
  logic                sow_out_q;
  logic                eow_out_q;

  logic [3:0]          w_valid;
  logic                w_found;
  logic [1:0]          w_win;
  logic [1:0]          w_idx;
  logic [WORD_W-1:0]   w_word;
  logic                w_accept;
  logic                w_xfer;

  assign w_valid = {bus.valid_in_3, bus.valid_in_2, bus.valid_in_1, bus.valid_in_0};

  // A new word may be taken while idle, or while the last byte of the
  // current word is on the lane so the next word follows without a bubble.
  assign w_accept = (state_q == IDLE) || (byte_cnt_q == LAST_CNT);

  // Round-robin search starting at rr_ptr_q.
  always_comb begin
    w_found = 1'b0;
    w_win   = 2'd0;
    w_idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      w_idx = rr_ptr_q + 2'(i);
      if (!w_found && w_valid[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    w_word = bus.data_in_0;
    case (w_win)
      2'd0:    w_word = bus.data_in_0;
      2'd1:    w_word = bus.data_in_1;
      2'd2:    w_word = bus.data_in_2;
      default: w_word = bus.data_in_3;
    endcase
  end

  assign w_xfer = w_accept && w_found;

  assign bus.ready_0 = w_xfer && (w_win == 2'd0);
  assign bus.ready_1 = w_xfer && (w_win == 2'd1);
  assign bus.ready_2 = w_xfer && (w_win == 2'd2);
  assign bus.ready_3 = w_xfer && (w_win == 2'd3);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      rr_ptr_q    <= 2'd0;
      shift_q     <= '0;
      data_out_q  <= IDLE_VAL;
      valid_out_q <= 1'b0;
      lane_out_q  <= 2'd0;
      sow_out_q   <= 1'b0;
      eow_out_q   <= 1'b0;
    end else if (w_xfer) begin
      // Byte 0 goes straight to the output register; the rest is queued.
      state_q     <= SEND;
      byte_cnt_q  <= '0;
      rr_ptr_q    <= w_win + 2'd1;
      shift_q     <= w_word << 8;
      data_out_q  <= w_word[WORD_W-1 -: 8];
      valid_out_q <= 1'b1;
      lane_out_q  <= w_win;
      sow_out_q   <= 1'b1;
      eow_out_q   <= (BYTES_PER_WORD == 1);
    end else if ((state_q == SEND) && (byte_cnt_q != LAST_CNT)) begin
      byte_cnt_q  <= byte_cnt_q + 1'b1;
      shift_q     <= shift_q << 8;
      data_out_q  <= shift_q[WORD_W-1 -: 8];
      sow_out_q   <= 1'b0;
      eow_out_q   <= (CNT_W'(byte_cnt_q + 1'b1) == LAST_CNT);
    end else begin
      // Idle, or last byte done with nobody waiting.
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      shift_q     <= '0;
      data_out_q  <= IDLE_VAL;
      valid_out_q <= 1'b0;
      lane_out_q  <= 2'd0;
      sow_out_q   <= 1'b0;
      eow_out_q   <= 1'b0;
    end
  end

  assign bus.data_out  = data_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.lane_out  = lane_out_q;
  assign bus.sow_out   = sow_out_q;
  assign bus.eow_out   = eow_out_q;

endmodule

`default_nettype wire

// File: tb/tb_byte_lane_rr_scheduler.sv
// ============================================================================
// Module      : tb_byte_lane_rr_scheduler
// Description : Directed self-checking bench for byte_lane_rr_scheduler.
//               Honours COMMA_EN for the expected idle byte.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_byte_lane_rr_scheduler;

`ifdef COMMA_EN
  localparam logic [7:0] IDLE_EXP = 8'hBC;
`else
  localparam logic [7:0] IDLE_EXP = 8'h00;
`endif

  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;

  byte_lane_rr_scheduler_if bus ();

  byte_lane_rr_scheduler dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Packed output view: {valid, sow, eow, lane[1:0], data[7:0]}
  function automatic logic [12:0] pk(input logic v, input logic s, input logic e,
                                     input logic [1:0] ln, input logic [7:0] d);
    return {v, s, e, ln, d};
  endfunction

  task automatic chk_out(input string tag, input logic [12:0] exp);
    logic [12:0] obs;
    obs = {bus.valid_out, bus.sow_out, bus.eow_out, bus.lane_out, bus.data_out};
    check_val(tag, 32'(obs), 32'(exp));
  endtask

  task automatic chk_rdy(input string tag, input logic [3:0] exp);
    check_val(tag, 32'({bus.ready_3, bus.ready_2, bus.ready_1, bus.ready_0}), 32'(exp));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.valid_in_0 = 1'b0; bus.valid_in_1 = 1'b0;
    bus.valid_in_2 = 1'b0; bus.valid_in_3 = 1'b0;
    bus.data_in_0  = '0;   bus.data_in_1  = '0;
    bus.data_in_2  = '0;   bus.data_in_3  = '0;
  endtask

  task automatic do_reset(input string tag);
    clear_in();
    reset_L = 1'b0;
    #1;
    chk_out({tag, "_rst_out"}, pk(1'b0, 1'b0, 1'b0, 2'd0, IDLE_EXP));
    chk_rdy({tag, "_rst_rdy"}, 4'b0000);
    @(posedge clk);
    #2;
    reset_L = 1'b1;
    #1;
  endtask

  // Called with byte 0 on the lane; returns with the last byte on the lane.
  task automatic expect_word(input string tag, input logic [1:0] ln, input logic [31:0] w);
    for (int b = 0; b < 4; b++) begin
      chk_out($sformatf("%s_b%0d", tag, b),
              pk(1'b1, b == 0, b == 3, ln, w[(31 - 8*b) -: 8]));
      if (b < 3) begin
        chk_rdy($sformatf("%s_b%0d_rdy", tag, b), 4'b0000);
        tick();
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    reset_L = 1'b0;
    clear_in();

    // 1: reset and idle
    do_reset("t1");
    tick();
    chk_out("t1_idle", pk(1'b0, 1'b0, 1'b0, 2'd0, IDLE_EXP));
    chk_rdy("t1_rdy", 4'b0000);

    // 2: single word from requester 0
    bus.valid_in_0 = 1'b1;
    bus.data_in_0  = 32'hFFDDAA00;
    #1;
    chk_rdy("t2_rdy", 4'b0001);
    tick();
    clear_in();
    expect_word("t2", 2'd0, 32'hFFDDAA00);
    chk_rdy("t2_last_rdy", 4'b0000);
    tick();
    chk_out("t2_idle", pk(1'b0, 1'b0, 1'b0, 2'd0, IDLE_EXP));

    // 3: all requesters busy, grants rotate with no bubbles
    do_reset("t3");
    bus.valid_in_0 = 1'b1; bus.data_in_0 = 32'h00000000;
    bus.valid_in_1 = 1'b1; bus.data_in_1 = 32'h01010101;
    bus.valid_in_2 = 1'b1; bus.data_in_2 = 32'h02020202;
    bus.valid_in_3 = 1'b1; bus.data_in_3 = 32'h03030303;
    #1;
    chk_rdy("t3_rdy0", 4'b0001);
    tick();
    for (int k = 0; k < 4; k++) begin
      expect_word($sformatf("t3_w%0d", k), 2'(k), {4{8'(k)}});
      chk_rdy($sformatf("t3_w%0d_last_rdy", k), 4'(1 << ((k + 1) % 4)));
      tick();
    end
    clear_in();
    expect_word("t3_wrap", 2'd0, 32'h00000000);
    tick();
    chk_out("t3_idle", pk(1'b0, 1'b0, 1'b0, 2'd0, IDLE_EXP));

    // 4: after granting 2, requesters 1 and 3 together -> 3 first
    do_reset("t4");
    bus.valid_in_2 = 1'b1;
    bus.data_in_2  = 32'h22334455;
    #1;
    chk_rdy("t4_rdy2", 4'b0100);
    tick();
    clear_in();
    bus.valid_in_1 = 1'b1; bus.data_in_1 = 32'h11111111;
    bus.valid_in_3 = 1'b1; bus.data_in_3 = 32'h33333333;
    expect_word("t4_l2", 2'd2, 32'h22334455);
    chk_rdy("t4_rdy3", 4'b1000);
    tick();
    bus.valid_in_3 = 1'b0;
    expect_word("t4_l3", 2'd3, 32'h33333333);
    chk_rdy("t4_rdy1", 4'b0010);
    tick();
    bus.valid_in_1 = 1'b0;
    expect_word("t4_l1", 2'd1, 32'h11111111);
    tick();
    chk_out("t4_idle", pk(1'b0, 1'b0, 1'b0, 2'd0, IDLE_EXP));

    // 5: reset during byte 2 of a lane 1 word
    do_reset("t5");
    bus.valid_in_1 = 1'b1;
    bus.data_in_1  = 32'hA1B2C3D4;
    #1;
    chk_rdy("t5_rdy1", 4'b0010);
    tick();
    chk_out("t5_b0", pk(1'b1, 1'b1, 1'b0, 2'd1, 8'hA1));
    tick();
    chk_out("t5_b1", pk(1'b1, 1'b0, 1'b0, 2'd1, 8'hB2));
    tick();
    chk_out("t5_b2", pk(1'b1, 1'b0, 1'b0, 2'd1, 8'hC3));
    #1;
    reset_L = 1'b0;
    #1;
    chk_out("t5_rst_now", pk(1'b0, 1'b0, 1'b0, 2'd0, IDLE_EXP));
    @(posedge clk);
    #2;
    // Requester 3 also waiting: a restarted pointer (0) must still pick 1.
    bus.valid_in_3 = 1'b1;
    bus.data_in_3  = 32'h33333333;
    reset_L = 1'b1;
    #1;
    chk_out("t5_after_rel", pk(1'b0, 1'b0, 1'b0, 2'd0, IDLE_EXP));
    chk_rdy("t5_rr_restart", 4'b0010);
    tick();
    clear_in();
    expect_word("t5_resend", 2'd1, 32'hA1B2C3D4);
    tick();
    chk_out("t5_idle", pk(1'b0, 1'b0, 1'b0, 2'd0, IDLE_EXP));

    // 6: requester 3 valid only on lane 0 last-byte cycle
    do_reset("t6");
    bus.valid_in_0 = 1'b1;
    bus.data_in_0  = 32'h0A0B0C0D;
    #1;
    chk_rdy("t6_rdy0", 4'b0001);
    tick();
    clear_in();
    expect_word("t6_l0", 2'd0, 32'h0A0B0C0D);
    bus.valid_in_3 = 1'b1;
    bus.data_in_3  = 32'h3C3D3E3F;
    #1;
    chk_rdy("t6_rdy3", 4'b1000);
    tick();
    clear_in();
    expect_word("t6_l3", 2'd3, 32'h3C3D3E3F);
    chk_rdy("t6_last_rdy", 4'b0000);
    tick();
    chk_out("t6_idle", pk(1'b0, 1'b0, 1'b0, 2'd0, IDLE_EXP));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
